// File: rtl/delay_tap_scheduler_if.sv
// ============================================================================
// Module      : delay_tap_scheduler_if
// Description : Single-requester memory port bundle between the delay tap
//               scheduler (master) and the shared sample memory (slave).
//   mem_req    master->slave  access request
//   mem_we     master->slave  1 = write, 0 = read (valid while mem_req)
//   mem_addr   master->slave  access address
//   mem_wdata  master->slave  write data
//   mem_ready  slave->master  access completes when mem_req && mem_ready
//   mem_rdata  slave->master  read data, valid in the completing cycle
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface delay_tap_scheduler_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/delay_tap_scheduler.sv
// ============================================================================
// Module      : delay_tap_scheduler
// Description : Per-sample sequencer for the shared sample memory. Each sample
//               tick writes one sample into a circular delay buffer spanning
//               BUF_BASE..2^AW-1, then issues up to MAX_TAPS delayed reads
//               (write pointer minus per-tap delay) and streams the results.
// Ports       :
//   clk, rst_n        clock, synchronous active-low reset
//   i_sample_tick     1-cycle strobe for a new sample
//   i_sample_in       sample recorded on the tick cycle
//   i_cfg_ntaps       taps per frame, clamped to MAX_TAPS
//   i_cfg_we/idx/delay tap-table write port (accepted only while o_cfg_ready)
//   o_cfg_ready       high only in IDLE
//   mem               memory port (delay_tap_scheduler_if.master)
//   o_tap_valid/idx/data returned tap, 1-cycle pulse
//   o_frame_done      1-cycle pulse at end of frame
//   o_overrun         sticky, tick arrived while busy
//   o_timeout         sticky, a ready wait expired
// Options     : `define MEMSCHED_TIMEOUT_EN to abandon accesses whose ready
//               wait reaches TIMEOUT cycles; otherwise waits forever.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module delay_tap_scheduler #(
  parameter int            AW       = 16,
  parameter int            DW       = 16,
  parameter int            MAX_TAPS = 8,
  parameter int            TW       = 3,
  parameter logic [AW-1:0] BUF_BASE = 16'h0100,
  parameter int            TIMEOUT  = 255
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  input  wire logic          i_sample_tick,
  input  wire logic [DW-1:0] i_sample_in,
  input  wire logic [TW:0]   i_cfg_ntaps,
  input  wire logic          i_cfg_we,
  input  wire logic [TW-1:0] i_cfg_idx,
  input  wire logic [AW-1:0] i_cfg_delay,
  output logic               o_cfg_ready,
  delay_tap_scheduler_if.master mem,
  output logic               o_tap_valid,
  output logic [TW-1:0]      o_tap_idx,
  output logic [DW-1:0]      o_tap_data,
  output logic               o_frame_done,
  output logic               o_overrun,
  output logic               o_timeout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_delay [MAX_TAPS];
  logic [TW:0]   r_n;
  logic [TW-1:0] r_k;
  logic          r_cfg_ready;
  logic          r_mem_req;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_tap_valid;
  logic [TW-1:0] r_tap_idx;
  logic [DW-1:0] r_tap_data;
  logic          r_frame_done;
  logic          r_overrun;

  logic          w_abandon;
  logic          w_complete;
  logic [DW-1:0] w_rdata;
  logic [TW:0]   w_ntaps;
  logic [TW-1:0] w_k_next;
  logic          w_last_tap;

  // Ring subtraction: a result below BUF_BASE (or a borrow) wraps by adding
  // L = 2^AW - BUF_BASE, which modulo 2^AW is the same as subtracting BUF_BASE.
  function automatic logic [AW-1:0] f_ring_addr(input logic [AW-1:0] ptr,
                                                input logic [AW-1:0] dly);
    logic [AW:0] diff;
    diff = {1'b0, ptr} - {1'b0, dly};
    if (diff[AW] || (diff[AW-1:0] < BUF_BASE))
      return diff[AW-1:0] - BUF_BASE;
    return diff[AW-1:0];
  endfunction

  assign w_ntaps    = (i_cfg_ntaps > (TW+1)'(MAX_TAPS)) ? (TW+1)'(MAX_TAPS) : i_cfg_ntaps;
  assign w_k_next   = r_k + 1'b1;
  assign w_last_tap = (({1'b0, r_k} + 1'b1) == r_n);
  assign w_complete = r_mem_req && (mem.mem_ready || w_abandon);
  // An abandoned read reports zero rather than whatever is on the bus.
  assign w_rdata    = mem.mem_ready ? mem.mem_rdata : '0;

`ifdef MEMSCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_wait_cnt;
  logic          r_timeout;

  // Abandon on the TIMEOUT-th consecutive stalled cycle of an access.
  assign w_abandon = r_mem_req && !mem.mem_ready && (r_wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else if (r_mem_req && !mem.mem_ready) begin
      if (w_abandon) begin
        r_wait_cnt <= '0;
        r_timeout  <= 1'b1;
      end else begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
    end else begin
      r_wait_cnt <= '0;
    end
  end

  assign o_timeout = r_timeout;
`else
  assign w_abandon = 1'b0;
  assign o_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= BUF_BASE;
      for (int i = 0; i < MAX_TAPS; i++) r_delay[i] <= '0;
      r_n          <= '0;
      r_k          <= '0;
      r_cfg_ready  <= 1'b1;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_tap_valid  <= 1'b0;
      r_tap_idx    <= '0;
      r_tap_data   <= '0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_tap_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      if (i_sample_tick && (r_state != S_IDLE)) r_overrun <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (i_cfg_we && r_cfg_ready) r_delay[i_cfg_idx] <= i_cfg_delay;
          if (i_sample_tick) begin
            r_n         <= w_ntaps;
            r_cfg_ready <= 1'b0;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_wr_ptr;
            r_mem_wdata <= i_sample_in;
            r_state     <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (w_complete) begin
            r_k      <= '0;
            r_mem_we <= 1'b0;
            if (r_n == '0) begin
              r_mem_req    <= 1'b0;
              r_frame_done <= 1'b1;
              r_state      <= S_DONE;
            end else begin
              r_mem_addr <= f_ring_addr(r_wr_ptr, r_delay[0]);
              r_state    <= S_READ;
            end
          end
        end
        S_READ: begin
          if (w_complete) begin
            r_tap_data  <= w_rdata;
            r_tap_idx   <= r_k;
            r_tap_valid <= 1'b1;
            if (w_last_tap) begin
              r_mem_req    <= 1'b0;
              r_frame_done <= 1'b1;
              r_state      <= S_DONE;
            end else begin
              r_k        <= w_k_next;
              r_mem_addr <= f_ring_addr(r_wr_ptr, r_delay[w_k_next]);
            end
          end
        end
        S_DONE: begin
          r_wr_ptr    <= (r_wr_ptr == {AW{1'b1}}) ? BUF_BASE : r_wr_ptr + 1'b1;
          r_cfg_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_cfg_ready   = r_cfg_ready;
  assign mem.mem_req   = r_mem_req;
  assign mem.mem_we    = r_mem_we;
  assign mem.mem_addr  = r_mem_addr;
  assign mem.mem_wdata = r_mem_wdata;
  assign o_tap_valid   = r_tap_valid;
  assign o_tap_idx     = r_tap_idx;
  assign o_tap_data    = r_tap_data;
  assign o_frame_done  = r_frame_done;
  assign o_overrun     = r_overrun;

endmodule

`default_nettype wire
